par_word_rx: RTL
================

# par_word_rx

Serial-to-parallel parity word receiver. It assembles a DATA_W-bit word plus one trailing parity bit from a bit-serial valid-qualified stream. It checks parity in odd or even mode and presents the word with a parity-error flag on a valid/ready output port. It is the upstream stage that feeds the word-parity checking path, and it turns the raw serial link into checked 32-bit words.

## Interface

- DATA_W, 32, data word width in bits (≥2)
- MSB_FIRST, 1, 1: first data bit received is out_data[DATA_W-1]; 0: first bit is out_data[0]
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_vld  input  1  qualifies in_bit/in_start this cycle
- in_bit  input  1  serial data/parity bit
- in_start  input  1  with in_vld: this beat is the first data bit of a new frame
- odd_mode  input  1  1: odd parity (data+parity ones count must be odd); 0: even; sampled on start beat only
- out_vld  output  1  word available
- out_rdy  input  1  downstream accepts word
- out_data  output  DATA_W  assembled word
- out_par_err  output  1  parity mismatch for out_data
- busy  output  1  frame in progress (state SHIFT or PAR)
- drop_cnt  output  8  saturating count of in_vld beats discarded
- abort_cnt  output  8  saturating count of frames aborted by a restart

## Operation

- States: IDLE, SHIFT, PAR, HOLD.
- IDLE:
  - in_vld&&in_start: latch odd_mode, store first bit, bit counter=1, go to SHIFT.
  - in_vld without in_start: dropped, drop_cnt++.
- SHIFT:
  - Each in_vld beat stores the next bit.
  - When counter reaches DATA_W, go to PAR.
  - in_vld&&in_start restarts the frame: the beat becomes bit 0, odd_mode is re-latched, abort_cnt++.
- PAR:
  - Next in_vld beat is the parity bit. Compute error = (^data ^ parity) != latched odd_mode. Load out_data/out_par_err, go to HOLD.
  - in_vld&&in_start in PAR is a restart, handled as in SHIFT (abort_cnt++); it is not used as parity.
- HOLD:
  - out_vld=1; out_data and out_par_err stay stable until the handshake.
  - out_vld&&out_rdy transfers the word. In the same cycle the input side behaves exactly as IDLE, so a start beat is accepted and the next state is SHIFT (or IDLE if no start).
  - Without out_rdy, every in_vld beat is dropped (drop_cnt++) and the state stays HOLD.
- Counters saturate at 255 and never wrap. They are cleared only by rst.
- No in_vld: state and counters hold. Gaps between beats are unlimited.

## Timing

- Reset values: out_vld=0, out_data=0, out_par_err=0, busy=0, drop_cnt=0, abort_cnt=0, state IDLE.
- All outputs are registered; none depends combinationally on inputs.
- Minimum frame is DATA_W+1 in_vld beats. out_vld rises in the cycle after the parity beat, so back-to-back input gives DATA_W+2 cycles from start beat to out_vld.
- With out_rdy held high, throughput is one word per DATA_W+1 beats. No bubble is required between a transfer and the next start beat.
- busy=1 from the cycle after the start beat through the cycle of the parity beat.
- rst asserted mid-frame or in HOLD discards the partial or held word immediately (async); outputs take reset values.
- odd_mode changes outside the start beat have no effect on the current frame.

## Structure

- Shared package holds:
  - state enum {IDLE, SHIFT, PAR, HOLD}
  - CNT_W=8 constant
  - PAR_ODD=1 / PAR_EVEN=0 localparams
- One natural sub-module: parity_calc, combinational. Inputs data[DATA_W-1:0], parity bit and mode; output err. It is reusable by downstream checkers.
- Bit counter width is $clog2(DATA_W+1).
- Shift register direction is selected by MSB_FIRST via generate.

## Test plan

- Odd mode: frame 0xFF005A1F (17 ones), parity 0, out_rdy=1 -> out_vld one cycle after parity beat, out_data=0xFF005A1F, out_par_err=0.
- Even mode: same word, parity 0 -> out_par_err=1. Odd mode: 0xFF825A5F (20 ones), parity 1 -> out_par_err=0.
- out_rdy=0 for 10 cycles after out_vld while sending 3 in_vld beats -> out_data stable, drop_cnt=3. Raising out_rdy together with a start beat -> transfer, state SHIFT, no drop counted.
- Start beat at bit 12 of a frame, then a full 0x0000_0001 frame in odd mode with parity 0 -> abort_cnt=1, out_data=0x00000001, out_par_err=0. Same restart at the parity beat -> abort_cnt=2.
- rst pulse mid-SHIFT, and again while in HOLD -> all outputs 0 asynchronously. The following complete frame is received correctly.
- 300 in_vld beats without start in IDLE -> drop_cnt saturates at 255. MSB_FIRST=0 build with 0x00000001 sent LSB-first -> out_data=0x00000001.

Source files
------------

// File: rtl/par_word_rx_pkg.sv
// Shared types and constants for the serial parity word receiver.
//   state_t  : receiver FSM states
//   CNT_W    : width of the saturating drop/abort counters
//   PAR_ODD / PAR_EVEN : encodings of the odd_mode input
package par_word_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int unsigned CNT_W = 8;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/par_word_rx_parity_calc.sv
// Combinational parity checker, reusable by downstream stages.
//   data : received data word
//   par  : received parity bit
//   mode : 1 = odd parity expected over data+par, 0 = even
//   err  : 1 when the ones count of data+par does not match mode
module par_word_rx_parity_calc #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    input  logic              mode,
    output logic              err
);

    assign err = ((^data) ^ par) != mode;

endmodule

// File: rtl/par_word_rx.sv
// Serial-to-parallel parity word receiver.
//   clk, rst              : clock, async active-high reset
//   in_vld/in_bit/in_start: bit-serial input beat, in_start marks bit 0
//   odd_mode              : parity mode, sampled on the start beat
//   out_vld/out_rdy       : output handshake
//   out_data/out_par_err  : assembled word and its parity-error flag
//   busy                  : frame in progress (SHIFT or PAR)
//   drop_cnt/abort_cnt    : saturating counts of dropped beats / restarted frames
module par_word_rx
    import par_word_rx_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              in_bit,
    input  logic              in_start,
    input  logic              odd_mode,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_err,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  abort_cnt
);

    localparam int unsigned          BIT_CNT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

    state_t               state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    sr, sr_shifted;
    logic                 mode;
    logic                 par_err_c;

    logic shift_en, start_frame, cnt_inc, drop_inc, abort_inc, out_ld;

    // Shift direction: MSB-first pushes in at bit 0, LSB-first pushes in at the top.
    // A restart needs no clear: exactly DATA_W further shifts flush the old bits.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shifted = {sr[DATA_W-2:0], in_bit};
        end else begin : g_lsb_first
            assign sr_shifted = {in_bit, sr[DATA_W-1:1]};
        end
    endgenerate

    par_word_rx_parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
        .data (sr),
        .par  (in_bit),
        .mode (mode),
        .err  (par_err_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt   = state;
        shift_en    = 1'b0;
        start_frame = 1'b0;
        cnt_inc     = 1'b0;
        drop_inc    = 1'b0;
        abort_inc   = 1'b0;
        out_ld      = 1'b0;
        case (state)
            IDLE: begin
                if (in_vld && in_start) begin
                    start_frame = 1'b1;
                    shift_en    = 1'b1;
                    state_nxt   = SHIFT;
                end else if (in_vld) begin
                    drop_inc = 1'b1;
                end
            end
            SHIFT: begin
                if (in_vld) begin
                    shift_en = 1'b1;
                    if (in_start) begin
                        start_frame = 1'b1;
                        abort_inc   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (bit_cnt == LAST_BIT) state_nxt = PAR;
                    end
                end
            end
            PAR: begin
                if (in_vld && in_start) begin
                    start_frame = 1'b1;
                    shift_en    = 1'b1;
                    abort_inc   = 1'b1;
                    state_nxt   = SHIFT;
                end else if (in_vld) begin
                    out_ld    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // On transfer the input side acts as IDLE in the same cycle.
                if (out_rdy) begin
                    state_nxt = IDLE;
                    if (in_vld && in_start) begin
                        start_frame = 1'b1;
                        shift_en    = 1'b1;
                        state_nxt   = SHIFT;
                    end else if (in_vld) begin
                        drop_inc = 1'b1;
                    end
                end else if (in_vld) begin
                    drop_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr          <= '0;
            bit_cnt     <= '0;
            mode        <= 1'b0;
            out_vld     <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
            busy        <= 1'b0;
            drop_cnt    <= '0;
            abort_cnt   <= '0;
        end else begin
            if (shift_en) sr <= sr_shifted;
            if (start_frame) begin
                bit_cnt <= BIT_CNT_W'(1);
                mode    <= odd_mode;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (out_ld) begin
                out_data    <= sr;
                out_par_err <= par_err_c;
            end
            out_vld <= (state_nxt == HOLD);
            busy    <= (state_nxt == SHIFT) || (state_nxt == PAR);
            if (drop_inc && drop_cnt != CNT_MAX)   drop_cnt  <= drop_cnt + CNT_W'(1);
            if (abort_inc && abort_cnt != CNT_MAX) abort_cnt <= abort_cnt + CNT_W'(1);
        end
    end

endmodule
